tetromino_queue: RTL and testbench

//  Next-piece preview queue plus hold slot, directly downstream of tetromino_generator.

---
 rtl/tetromino_queue.sv | 154 +++++++++++++++
 tb/tb_tetromino_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tetromino_queue.sv
// tetromino_queue: next-piece preview queue with a one-per-spawn hold slot.
// Pulls pieces from tetromino_generator one at a time, buffers DEPTH of them,
// serves the active piece on spawn and implements hold/swap.
module tetromino_queue #(
  parameter int DEPTH = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [2:0]         gen_idx,
  input  logic               spawn_req,
  input  logic               hold_req,
  output logic               gen_req,
  output logic [2:0]         cur_idx,
  output logic               cur_valid,
  output logic [2:0]         hold_idx,
  output logic               hold_valid,
  output logic               hold_used,
  output logic [3*DEPTH-1:0] next_idx,
  output logic [2:0]         count,
  output logic               ready
);

  typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

  state_t     state_q, state_d;
  logic [2:0] slot_q [DEPTH];
  logic [2:0] slot_d [DEPTH];
  logic [2:0] count_q, count_d;
  logic [2:0] cur_q, cur_d;
  logic [2:0] hold_q, hold_d;
  logic       curValid_q, curValid_d;
  logic       holdValid_q, holdValid_d;
  logic       holdUsed_q, holdUsed_d;
  logic       genReq_q;
  logic       ready_q;

  logic       spawnAcc, holdAcc, holdPop, pop, capture;
  logic [2:0] genClean;

  // Decode which requests are accepted this cycle; spawn always beats hold.
  always_comb begin
    spawnAcc = spawn_req && (count_q != 3'd0);
    holdAcc  = hold_req && !spawn_req && curValid_q && !holdUsed_q &&
               (holdValid_q || (count_q != 3'd0));
    holdPop  = holdAcc && !holdValid_q;
    pop      = spawnAcc || holdPop;
    capture  = (state_q == CAP);
    genClean = (gen_idx == 3'd7) ? 3'd0 : gen_idx;
  end

  // Next-state datapath: pop/shift first, then land any captured piece after it.
  always_comb begin
    slot_d      = slot_q;
    count_d     = count_q;
    cur_d       = cur_q;
    hold_d      = hold_q;
    curValid_d  = curValid_q;
    holdValid_d = holdValid_q;
    holdUsed_d  = holdUsed_q;

    if (spawnAcc) begin
      cur_d      = slot_q[0];
      curValid_d = 1'b1;
      holdUsed_d = 1'b0;
    end else if (holdAcc) begin
      holdUsed_d = 1'b1;
      if (holdValid_q) begin
        cur_d  = hold_q;
        hold_d = cur_q;
      end else begin
        hold_d      = cur_q;
        holdValid_d = 1'b1;
        cur_d       = slot_q[0];
      end
    end

    if (pop) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k+1];
      end
      slot_d[DEPTH-1] = 3'd0;
      count_d = count_q - 3'd1;
    end

    if (capture) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (count_d == 3'(k)) begin
          slot_d[k] = genClean;
        end
      end
      count_d = count_d + 3'd1;
    end
  end

  // Refill FSM: one generator request in flight at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q < 3'(DEPTH)) state_d = REQ;
      REQ:     state_d = CAP;
      CAP:     state_d = (count_d < 3'(DEPTH)) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; Reset also discards any capture in progress.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      cur_q       <= 3'd0;
      hold_q      <= 3'd0;
      curValid_q  <= 1'b0;
      holdValid_q <= 1'b0;
      holdUsed_q  <= 1'b0;
      genReq_q    <= 1'b0;
      ready_q     <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      hold_q      <= hold_d;
      curValid_q  <= curValid_d;
      holdValid_q <= holdValid_d;
      holdUsed_q  <= holdUsed_d;
      genReq_q    <= (state_d == REQ);
      ready_q     <= (count_d != 3'd0);
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Flatten the preview slots for the sidebar renderer.
  always_comb begin
    next_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      next_idx[3*k +: 3] = slot_q[k];
    end
  end

  assign gen_req    = genReq_q;
  assign cur_idx    = cur_q;
  assign cur_valid  = curValid_q;
  assign hold_idx   = hold_q;
  assign hold_valid = holdValid_q;
  assign hold_used  = holdUsed_q;
  assign count      = count_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_tetromino_queue.sv
// Testbench for tetromino_queue: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_tetromino_queue;

  localparam int DEPTH = 3;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic [2:0]         gen_idx = 3'd0;
  logic               spawn_req = 1'b0;
  logic               hold_req = 1'b0;
  logic               gen_req;
  logic [2:0]         cur_idx;
  logic               cur_valid;
  logic [2:0]         hold_idx;
  logic               hold_valid;
  logic               hold_used;
  logic [3*DEPTH-1:0] next_idx;
  logic [2:0]         count;
  logic               ready;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: preview as a plain queue plus request/capture timing flags.
  int q[$];
  int genScript[$];
  bit mGenReq, mCap, mCurV, mHoldV, mUsed;
  int mCur, mHold;

  always #5 Clk = ~Clk;

  tetromino_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .gen_idx(gen_idx), .spawn_req(spawn_req),
    .hold_req(hold_req), .gen_req(gen_req), .cur_idx(cur_idx),
    .cur_valid(cur_valid), .hold_idx(hold_idx), .hold_valid(hold_valid),
    .hold_used(hold_used), .next_idx(next_idx), .count(count), .ready(ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3*DEPTH-1:0] packPreview();
    logic [3*DEPTH-1:0] e = '0;
    for (int k = 0; k < q.size(); k++) e[3*k +: 3] = 3'(q[k]);
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic modelEdge(input bit sp, input bit ho, input bit rst, input int g);
    int oldSize, tmp;
    bit newReq;
    if (rst) begin
      q.delete();
      mGenReq = 0; mCap = 0; mCurV = 0; mHoldV = 0; mUsed = 0; mCur = 0; mHold = 0;
      return;
    end
    oldSize = q.size();
    if (sp && oldSize > 0) begin
      mCur = q.pop_front(); mCurV = 1; mUsed = 0;
    end else if (ho && !sp && mCurV && !mUsed) begin
      if (mHoldV) begin
        tmp = mCur; mCur = mHold; mHold = tmp; mUsed = 1;
      end else if (oldSize > 0) begin
        mHold = mCur; mHoldV = 1; mCur = q.pop_front(); mUsed = 1;
      end
    end
    if (mCap) q.push_back((g == 7) ? 0 : g);
    if (mCap) newReq = (q.size() < DEPTH);
    else      newReq = !mGenReq && (oldSize < DEPTH);
    mCap = mGenReq;
    mGenReq = newReq;
  endtask

  // Drive one cycle of inputs, clock it, then compare every output to the model.
  task automatic applyStimulus(input bit sp, input bit ho, input bit rst);
    int g;
    if (mCap && genScript.size() > 0) g = genScript.pop_front();
    else g = int'($urandom_range(0, 7));
    gen_idx = 3'(g); spawn_req = sp; hold_req = ho; Reset = rst;
    @(posedge Clk);
    modelEdge(sp, ho, rst, g);
    #1;
    checkOutput("gen_req",    gen_req,    mGenReq);
    checkOutput("cur_idx",    cur_idx,    mCur);
    checkOutput("cur_valid",  cur_valid,  mCurV);
    checkOutput("hold_idx",   hold_idx,   mHold);
    checkOutput("hold_valid", hold_valid, mHoldV);
    checkOutput("hold_used",  hold_used,  mUsed);
    checkOutput("next_idx",   next_idx,   packPreview());
    checkOutput("count",      count,      q.size());
    checkOutput("ready",      ready,      q.size() != 0);
  endtask

  task automatic waitCapture(input string tag);
    int n = 0;
    while (!mCap && n < 10) begin
      applyStimulus(0, 0, 0);
      n++;
    end
    checkOutput(tag, mCap, 1);
  endtask

  initial begin
    int prevSlot1;
    modelEdge(0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 1);
    checkOutput("reset count", count, 0);

    // Fill from empty with a known generator sequence.
    genScript = '{2, 5, 1};
    applyStimulus(0, 0, 0);
    checkOutput("T1 first gen_req", gen_req, 1);
    repeat (6) applyStimulus(0, 0, 0);
    checkOutput("T1 preview", next_idx, {3'd1, 3'd5, 3'd2});
    checkOutput("T1 count", count, 3);
    checkOutput("T1 ready", ready, 1);

    // Spawn from a full queue, then refill with 4.
    applyStimulus(1, 0, 0);
    checkOutput("T2 cur", cur_idx, 2);
    checkOutput("T2 preview", next_idx, {3'd0, 3'd1, 3'd5});
    genScript = '{4};
    applyStimulus(0, 0, 0);
    checkOutput("T2 gen_req", gen_req, 1);
    repeat (3) applyStimulus(0, 0, 0);
    checkOutput("T2 slot2", next_idx[8:6], 4);

    // Hold into empty slot, blocked repeat, spawn re-arms, then swap.
    applyStimulus(0, 1, 0);
    checkOutput("T3 hold", hold_idx, 2);
    checkOutput("T3 cur", cur_idx, 5);
    checkOutput("T3 used", hold_used, 1);
    applyStimulus(0, 1, 0);
    checkOutput("T3 blocked cur", cur_idx, 5);
    repeat (4) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("T3 rearm", hold_used, 0);
    applyStimulus(0, 1, 0);
    checkOutput("T3 swap hold", hold_idx, 1);
    checkOutput("T3 swap cur", cur_idx, 2);

    // Spawn landing on a capture cycle with two pieces buffered.
    repeat (6) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    waitCapture("T4 capture reached");
    checkOutput("T4 pre count", count, 2);
    prevSlot1 = q[1];
    genScript = '{6};
    applyStimulus(1, 0, 0);
    checkOutput("T4 slot0", next_idx[2:0], prevSlot1);
    checkOutput("T4 slot1", next_idx[5:3], 6);
    checkOutput("T4 count", count, 2);

    // Spawn and hold together; then spawn on an empty queue.
    repeat (6) applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("T5 hold dropped", hold_used, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("T5 empty cur_valid", cur_valid, 0);

    // Reset in the middle of a capture.
    waitCapture("T6 capture reached");
    applyStimulus(0, 0, 1);
    checkOutput("T6 count", count, 0);
    checkOutput("T6 preview", next_idx, 0);
    applyStimulus(0, 0, 0);
    checkOutput("T6 restart gen_req", gen_req, 1);

    // Random traffic, including stray gen_idx==7 and occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
